// File: rtl/hex_count_display_if.sv
// Bundle of the counter controls and the multiplexed 7-segment display outputs.
// The master side drives the controls; the slave side (the display block) drives the outputs.
interface hex_count_display_if;
    logic        div_clk;
    logic        en;
    logic        up;
    logic        clr;
    logic [15:0] count;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    modport master (
        output div_clk,
        output en,
        output up,
        output clr,
        input  count,
        input  seg,
        input  dp,
        input  an
    );

    modport slave (
        input  div_clk,
        input  en,
        input  up,
        input  clr,
        output count,
        output seg,
        output dp,
        output an
    );
endinterface

// File: rtl/hex_count_display.sv
// 16-bit up/down counter of div_clk rising edges, shown in hex on a 4-digit
// common-anode multiplexed 7-segment display. div_clk is sampled as data, never used as a clock.
module hex_count_display #(
    parameter int SCAN_CYCLES   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic               clkin,
    input  logic               rst_n,
    hex_count_display_if.slave bus
);

    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

    logic              div_q;
    logic              tick;
    logic [15:0]       count_q, count_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [1:0]        idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        an_q, an_d;
    logic [3:0]        nibble;
    logic [15:0]       upper;
    logic              blank;

    function automatic logic [6:0] hexToSeg(input logic [3:0] value);
        logic [6:0] code;
        code = 7'h7F;
        case (value)
            4'h0: code = 7'h40;
            4'h1: code = 7'h79;
            4'h2: code = 7'h24;
            4'h3: code = 7'h30;
            4'h4: code = 7'h19;
            4'h5: code = 7'h12;
            4'h6: code = 7'h02;
            4'h7: code = 7'h78;
            4'h8: code = 7'h00;
            4'h9: code = 7'h10;
            4'hA: code = 7'h08;
            4'hB: code = 7'h03;
            4'hC: code = 7'h46;
            4'hD: code = 7'h21;
            4'hE: code = 7'h06;
            4'hF: code = 7'h0E;
            default: code = 7'h7F;
        endcase
        return code;
    endfunction

    // Clear outranks a tick; ticks seen while disabled are simply dropped.
    always_comb begin
        tick    = bus.div_clk & ~div_q;
        count_d = count_q;
        if (bus.clr) begin
            count_d = 16'h0000;
        end else if (tick && bus.en) begin
            count_d = bus.up ? (count_q + 16'd1) : (count_q - 16'd1);
        end
    end

    always_comb begin
        scan_d = scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end
    end

    // A digit is blank only if it and every digit to its left hold zero.
    always_comb begin
        nibble = count_q[{idx_q, 2'b00} +: 4];
        upper  = count_q >> {idx_q, 2'b00};
        blank  = (BLANK_LEADING != 1'b0) && (idx_q != 2'd0) && (upper == 16'h0000);
        seg_d  = blank ? 7'h7F : hexToSeg(nibble);
        an_d   = ~(4'b0001 << idx_q);
        dp_d   = ~((idx_q == 2'd0) & ~bus.up);
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= 1'b1;
            count_q <= 16'h0000;
            scan_q  <= '0;
            idx_q   <= 2'd0;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            an_q    <= 4'b1111;
        end else begin
            div_q   <= bus.div_clk;
            count_q <= count_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign bus.count = count_q;
    assign bus.seg   = seg_q;
    assign bus.dp    = dp_q;
    assign bus.an    = an_q;

endmodule

// File: tb/tb_hex_count_display.sv
// Scoreboard bench for hex_count_display: two instances (blanking on and off) share stimulus,
// a cycle-level reference model queues expected outputs and a monitor compares them.
module tb_hex_count_display;

    localparam int SCAN = 4;
    localparam logic [6:0] SEG_CODE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic [15:0] count;
        logic [3:0]  an;
        logic [6:0]  segBlank;
        logic [6:0]  segNoBlank;
        logic        dp;
    } expT;

    logic clkin;
    logic rst_n;

    hex_count_display_if ifBlank ();
    hex_count_display_if ifNoBlank ();

    hex_count_display #(.SCAN_CYCLES(SCAN), .BLANK_LEADING(1'b1)) dutBlank (
        .clkin (clkin),
        .rst_n (rst_n),
        .bus   (ifBlank.slave)
    );

    hex_count_display #(.SCAN_CYCLES(SCAN), .BLANK_LEADING(1'b0)) dutNoBlank (
        .clkin (clkin),
        .rst_n (rst_n),
        .bus   (ifNoBlank.slave)
    );

    expT sb [$];
    expT monExp;
    int  checks   = 0;
    int  failures = 0;

    int   mCount   = 0;
    int   mEdges   = 0;
    logic mPrevDiv = 1'b1;
    logic prevRst  = 1'b0;

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog expired before the bench completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at time %0t", name, act, req, $time);
        end
    endtask

    // Reference model: the shown digit follows purely from edges elapsed since reset release.
    task automatic applyStimulus(input logic r, input logic dv, input logic e, input logic u, input logic c);
        expT x;
        int  d;
        int  upperVal;
        @(negedge clkin);
        rst_n = r;
        ifBlank.div_clk = dv;   ifNoBlank.div_clk = dv;
        ifBlank.en      = e;    ifNoBlank.en      = e;
        ifBlank.up      = u;    ifNoBlank.up      = u;
        ifBlank.clr     = c;    ifNoBlank.clr     = c;
        if (!r) begin
            x.count = 16'h0000; x.an = 4'b1111; x.segBlank = 7'h7F; x.segNoBlank = 7'h7F; x.dp = 1'b1;
            mCount = 0; mEdges = 0; mPrevDiv = 1'b1;
        end else begin
            d        = (mEdges / SCAN) % 4;
            upperVal = mCount >> (4 * d);
            x.an         = ~(4'b0001 << d);
            x.segNoBlank = SEG_CODE[upperVal % 16];
            x.segBlank   = (d > 0 && upperVal == 0) ? 7'h7F : SEG_CODE[upperVal % 16];
            x.dp         = !(d == 0 && !u);
            if (c)                  mCount = 0;
            else if (dv && !mPrevDiv && e) mCount = (mCount + (u ? 1 : 65535)) % 65536;
            x.count  = 16'(mCount);
            mPrevDiv = dv;
            mEdges++;
        end
        sb.push_back(x);
        if (!r && prevRst) begin
            #1;
            checkOutput("async_rst_count", ifBlank.count, 16'h0000);
            checkOutput("async_rst_an", {12'h0, ifBlank.an}, 16'h000F);
            checkOutput("async_rst_seg", {9'h0, ifBlank.seg}, 16'h007F);
            checkOutput("async_rst_dp", {15'h0, ifBlank.dp}, 16'h0001);
        end
        prevRst = r;
    endtask

    task automatic tickOnce(input logic e, input logic u);
        applyStimulus(1'b1, 1'b0, e, u, 1'b0);
        applyStimulus(1'b1, 1'b1, e, u, 1'b0);
    endtask

    task automatic hold(input int n, input logic u);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b1, u, 1'b0);
    endtask

    always begin
        @(posedge clkin);
        #1;
        if (sb.size() > 0) begin
            monExp = sb.pop_front();
            checkOutput("count", ifBlank.count, monExp.count);
            checkOutput("count_noblank", ifNoBlank.count, monExp.count);
            checkOutput("an", {12'h0, ifBlank.an}, {12'h0, monExp.an});
            checkOutput("an_noblank", {12'h0, ifNoBlank.an}, {12'h0, monExp.an});
            checkOutput("seg_blank", {9'h0, ifBlank.seg}, {9'h0, monExp.segBlank});
            checkOutput("seg_noblank", {9'h0, ifNoBlank.seg}, {9'h0, monExp.segNoBlank});
            checkOutput("dp", {15'h0, ifBlank.dp}, {15'h0, monExp.dp});
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        ifBlank.div_clk = 1'b1; ifNoBlank.div_clk = 1'b1;
        ifBlank.en = 1'b0;      ifNoBlank.en = 1'b0;
        ifBlank.up = 1'b1;      ifNoBlank.up = 1'b1;
        ifBlank.clr = 1'b0;     ifNoBlank.clr = 1'b0;

        // div_clk high across reset release must not count.
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tickOnce(1'b1, 1'b1);

        // Wrap both ways and show the down-count decimal point.
        tickOnce(1'b1, 1'b0);
        tickOnce(1'b1, 1'b0);
        tickOnce(1'b1, 1'b1);
        tickOnce(1'b1, 1'b0);
        hold(16, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 16'h1234; i++) tickOnce(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tickOnce(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        hold(4, 1'b1);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 16'h4111; i++) tickOnce(1'b1, 1'b0);
        hold(40, 1'b1);

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 16'h00A5; i++) tickOnce(1'b1, 1'b1);
        hold(20, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        hold(20, 1'b1);

        for (int i = 0; i < 16'h0F0F; i++) tickOnce(1'b1, 1'b1);
        guard = 0;
        while (((mEdges / SCAN) % 4) != 2 && guard < 64) begin
            hold(1, 1'b1);
            guard++;
        end
        checkOutput("reach_digit2", 16'(guard < 64), 16'h0001);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        hold(20, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 199) != 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 31) == 0));
        end
        hold(4, 1'b1);

        repeat (3) @(negedge clkin);
        checkOutput("sb_drain", 16'(sb.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
